xf_load_sequencer: RTL

- Command-processor-side initiator for XF loads.
- Consumes the CP LOAD_XF payload stream: one header word, then 1..2^LEN_WIDTH data words.
- Emits one registered write strobe per data word on the CP bus (CPAddr / CPWriteData / CPWriteMatrix / CPWriteReg) that drives the transform unit.
- Sits between the CP FIFO/opcode parser and the XF.

---
 rtl/xf_load_sequencer_if.sv | 34 +++
 rtl/xf_load_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/xf_load_sequencer_if.sv
// Payload-stream and CP-bus signal bundle for xf_load_sequencer.
// loadError/errClear exist only when XF_RANGE_CHECK_EN is defined.
interface xf_load_sequencer_if;
  logic [31:0] inWord;
  logic        inValid;
  logic        inReady;
  logic [11:0] CPAddr;
  logic [31:0] CPWriteData;
  logic        CPWriteMatrix;
  logic        CPWriteReg;
  logic        busy;
`ifdef XF_RANGE_CHECK_EN
  logic        loadError;
  logic        errClear;

  modport master (
    input  inWord, inValid, errClear,
    output inReady, CPAddr, CPWriteData, CPWriteMatrix, CPWriteReg, busy, loadError
  );
  modport slave (
    output inWord, inValid, errClear,
    input  inReady, CPAddr, CPWriteData, CPWriteMatrix, CPWriteReg, busy, loadError
  );
`else
  modport master (
    input  inWord, inValid,
    output inReady, CPAddr, CPWriteData, CPWriteMatrix, CPWriteReg, busy
  );
  modport slave (
    output inWord, inValid,
    input  inReady, CPAddr, CPWriteData, CPWriteMatrix, CPWriteReg, busy
  );
`endif
endinterface

// File: rtl/xf_load_sequencer.sv
// XF load sequencer: turns a LOAD_XF header + data stream into registered CP-bus writes.
// Optional XF_RANGE_CHECK_EN drops writes beyond the XF register window and flags loadError.
module xf_load_sequencer #(
  parameter int LEN_LSB   = 16,
  parameter int LEN_WIDTH = 4,
  parameter int REG_SPAN  = 256
) (
  input logic                  clk,
  input logic                  resetn,
  xf_load_sequencer_if.master  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DATA = 1'b1
  } state_t;

  state_t               state;
  logic [15:0]          addr;
  logic [LEN_WIDTH-1:0] remaining;
  logic                 xferS;
  logic                 wrMatrixS;
  logic                 wrRegS;
  logic                 wrErrS;

`ifdef XF_RANGE_CHECK_EN
  localparam logic [16:0] REG_LIMIT = 17'h01000 + 17'(REG_SPAN);

  function automatic logic inXfWindow(input logic [15:0] a);
    return ({1'b0, a} < REG_LIMIT);
  endfunction
`else
  localparam int unusedRegSpan = REG_SPAN;
`endif

  // The block never back-pressures the parser.
  assign bus.inReady = 1'b1;
  assign xferS       = bus.inValid & bus.inReady;

  // Write decode for the data word being accepted this cycle.
  always_comb begin
    wrMatrixS = 1'b0;
    wrRegS    = 1'b0;
    wrErrS    = 1'b0;
    if ((state == DATA) && xferS) begin
`ifdef XF_RANGE_CHECK_EN
      if (inXfWindow(addr)) begin
        wrMatrixS = ~addr[12];
        wrRegS    = addr[12];
      end else begin
        wrErrS    = 1'b1;
      end
`else
      wrMatrixS = ~addr[12];
      wrRegS    = addr[12];
`endif
    end else begin
      wrMatrixS = 1'b0;
      wrRegS    = 1'b0;
      wrErrS    = 1'b0;
    end
  end

  // Header/data FSM with registered CP-bus outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state             <= IDLE;
      addr              <= 16'h0000;
      remaining         <= {LEN_WIDTH{1'b0}};
      bus.CPAddr        <= 12'h000;
      bus.CPWriteData   <= 32'h0000_0000;
      bus.CPWriteMatrix <= 1'b0;
      bus.CPWriteReg    <= 1'b0;
      bus.busy          <= 1'b0;
`ifdef XF_RANGE_CHECK_EN
      bus.loadError     <= 1'b0;
`endif
    end else begin
      bus.CPWriteMatrix <= wrMatrixS;
      bus.CPWriteReg    <= wrRegS;
      if (wrMatrixS || wrRegS) begin
        bus.CPAddr      <= addr[11:0];
        bus.CPWriteData <= bus.inWord;
      end
`ifdef XF_RANGE_CHECK_EN
      // A new error outranks a simultaneous clear.
      if (wrErrS) begin
        bus.loadError <= 1'b1;
      end else if (bus.errClear) begin
        bus.loadError <= 1'b0;
      end
`endif
      case (state)
        IDLE: begin
          if (xferS) begin
            addr      <= bus.inWord[15:0];
            remaining <= bus.inWord[LEN_LSB+LEN_WIDTH-1:LEN_LSB];
            state     <= DATA;
            bus.busy  <= 1'b1;
          end
        end
        DATA: begin
          if (xferS) begin
            if (remaining == {LEN_WIDTH{1'b0}}) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end else begin
              remaining <= remaining - {{(LEN_WIDTH-1){1'b0}}, 1'b1};
              addr      <= addr + 16'd1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
